// File: rtl/stage_round_ctrl.sv
// rtl/stage_round_ctrl.sv - game-round sequencer for the jump game
//
// Purpose: drives the stage-fall animator (generate_en/update/fall_en),
// runs the key-charge / jump / landing-judge loop, accumulates the score
// and flags game over.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start             one-cycle start/restart request (IDLE only)
//   key               debounced jump key level, 1 = pressed
//   pulse             one-cycle frame tick
//   fall_fin          stage fall complete (FALL only)
//   jump_fin          jump trajectory complete (JUMP only)
//   land_ok           landed on stage, valid with jump_fin
//   land_center       landed in centre zone, valid with land_ok
//   generate_en       load initial stage, high for the GEN cycle
//   update            restart fall, high for the UPDATE cycle
//   fall_en           animator enable, high throughout FALL
//   jump_start        high for the first JUMP cycle
//   jump_en           high throughout JUMP
//   jump_power        charge latched at key release
//   charge            live charge value
//   score             current score
//   game_over         round lost (held in IDLE)
//   fall_err          sticky: FALL left via timeout
//   state             FSM state code
//
// Optional feature macro: PERFECT_BONUS_EN (centre landings score +2).

module stage_round_ctrl #(
  parameter int CHARGE_W     = 8,
  parameter int CHARGE_MAX   = 200,
  parameter int SCORE_W      = 10,
  parameter int FALL_TIMEOUT = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                key,
  input  logic                pulse,
  input  logic                fall_fin,
  input  logic                jump_fin,
  input  logic                land_ok,
  input  logic                land_center,
  output logic                generate_en,
  output logic                update,
  output logic                fall_en,
  output logic                jump_start,
  output logic                jump_en,
  output logic [CHARGE_W-1:0] jump_power,
  output logic [CHARGE_W-1:0] charge,
  output logic [SCORE_W-1:0]  score,
  output logic                game_over,
  output logic                fall_err,
  output logic [2:0]          state
);

  localparam int TO_W = $clog2(FALL_TIMEOUT + 1);

`ifdef PERFECT_BONUS_EN
  localparam logic BONUS_ON = 1'b1;
`else
  localparam logic BONUS_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN      = 3'd1,
    S_WAIT_KEY = 3'd2,
    S_CHARGE   = 3'd3,
    S_JUMP     = 3'd4,
    S_JUDGE    = 3'd5,
    S_UPDATE   = 3'd6,
    S_FALL     = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic                key_prev_q, key_prev_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                land_ok_q, land_ok_d;
  logic                land_center_q, land_center_d;
  logic [CHARGE_W-1:0] charge_q, charge_d;
  logic [CHARGE_W-1:0] jump_power_q, jump_power_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                game_over_q, game_over_d;
  logic                fall_err_q, fall_err_d;
  logic                generate_en_q, generate_en_d;
  logic                update_q, update_d;
  logic                fall_en_q, fall_en_d;
  logic                jump_start_q, jump_start_d;
  logic                jump_en_q, jump_en_d;

  logic [CHARGE_W-1:0] charge_next;
  logic [TO_W-1:0]     to_cnt_next;
  logic [1:0]          score_step;
  logic [SCORE_W:0]    score_sum;

  always_comb begin
    state_d       = state_q;
    key_prev_d    = key;
    to_cnt_d      = to_cnt_q;
    land_ok_d     = land_ok_q;
    land_center_d = land_center_q;
    charge_d      = charge_q;
    jump_power_d  = jump_power_q;
    score_d       = score_q;
    game_over_d   = game_over_q;
    fall_err_d    = fall_err_q;

    // A pulse coinciding with key release still counts before latching.
    if (pulse && (charge_q < CHARGE_W'(CHARGE_MAX)))
      charge_next = charge_q + CHARGE_W'(1);
    else
      charge_next = charge_q;

    to_cnt_next = pulse ? to_cnt_q + TO_W'(1) : to_cnt_q;

    score_step = (BONUS_ON && land_center_q) ? 2'd2 : 2'd1;
    score_sum  = {1'b0, score_q} + {{(SCORE_W - 1){1'b0}}, score_step};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_GEN;
          score_d     = '0;
          game_over_d = 1'b0;
          fall_err_d  = 1'b0;
        end
      end
      S_GEN: state_d = S_WAIT_KEY;
      S_WAIT_KEY: begin
        // Edge detect: a key still held from earlier must be released first.
        if (key && !key_prev_q) begin
          state_d  = S_CHARGE;
          charge_d = '0;
        end
      end
      S_CHARGE: begin
        charge_d = charge_next;
        if (!key) begin
          state_d      = S_JUMP;
          jump_power_d = charge_next;
        end
      end
      S_JUMP: begin
        if (jump_fin) begin
          state_d       = S_JUDGE;
          land_ok_d     = land_ok;
          land_center_d = land_center;
        end
      end
      S_JUDGE: begin
        if (land_ok_q) begin
          state_d = S_UPDATE;
          score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end else begin
          state_d     = S_IDLE;
          game_over_d = 1'b1;
        end
      end
      S_UPDATE: begin
        state_d  = S_FALL;
        to_cnt_d = '0;
      end
      S_FALL: begin
        to_cnt_d = to_cnt_next;
        if (fall_fin) begin
          state_d = S_WAIT_KEY;
        end else if (to_cnt_next >= TO_W'(FALL_TIMEOUT)) begin
          state_d    = S_WAIT_KEY;
          fall_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered off the next state so each is high exactly
    // for the cycle(s) the FSM occupies the matching state.
    generate_en_d = (state_d == S_GEN);
    update_d      = (state_d == S_UPDATE);
    fall_en_d     = (state_d == S_FALL);
    jump_en_d     = (state_d == S_JUMP);
    jump_start_d  = (state_d == S_JUMP) && (state_q == S_CHARGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      key_prev_q    <= 1'b0;
      to_cnt_q      <= '0;
      land_ok_q     <= 1'b0;
      land_center_q <= 1'b0;
      charge_q      <= '0;
      jump_power_q  <= '0;
      score_q       <= '0;
      game_over_q   <= 1'b0;
      fall_err_q    <= 1'b0;
      generate_en_q <= 1'b0;
      update_q      <= 1'b0;
      fall_en_q     <= 1'b0;
      jump_start_q  <= 1'b0;
      jump_en_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_prev_q    <= key_prev_d;
      to_cnt_q      <= to_cnt_d;
      land_ok_q     <= land_ok_d;
      land_center_q <= land_center_d;
      charge_q      <= charge_d;
      jump_power_q  <= jump_power_d;
      score_q       <= score_d;
      game_over_q   <= game_over_d;
      fall_err_q    <= fall_err_d;
      generate_en_q <= generate_en_d;
      update_q      <= update_d;
      fall_en_q     <= fall_en_d;
      jump_start_q  <= jump_start_d;
      jump_en_q     <= jump_en_d;
    end
  end

  assign generate_en = generate_en_q;
  assign update      = update_q;
  assign fall_en     = fall_en_q;
  assign jump_start  = jump_start_q;
  assign jump_en     = jump_en_q;
  assign jump_power  = jump_power_q;
  assign charge      = charge_q;
  assign score       = score_q;
  assign game_over   = game_over_q;
  assign fall_err    = fall_err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_stage_round_ctrl.sv
// tb/tb_stage_round_ctrl.sv - directed self-checking bench for stage_round_ctrl

module tb_stage_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, key, pulse, fall_fin, jump_fin, land_ok, land_center;
  logic       generate_en, update, fall_en, jump_start, jump_en;
  logic [7:0] jump_power, charge;
  logic [9:0] score;
  logic       game_over, fall_err;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  int exp_bonus_score;

  always #5 clk = ~clk;

  stage_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .pulse(pulse),
    .fall_fin(fall_fin), .jump_fin(jump_fin), .land_ok(land_ok),
    .land_center(land_center), .generate_en(generate_en), .update(update),
    .fall_en(fall_en), .jump_start(jump_start), .jump_en(jump_en),
    .jump_power(jump_power), .charge(charge), .score(score),
    .game_over(game_over), .fall_err(fall_err), .state(state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pulse = 1'b1;
      step();
      pulse = 1'b0;
      step();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef PERFECT_BONUS_EN
    exp_bonus_score = 3;
`else
    exp_bonus_score = 2;
`endif
    rst = 1'b1; start = 0; key = 0; pulse = 0; fall_fin = 0;
    jump_fin = 0; land_ok = 0; land_center = 0;
    step(); step();
    check("rst_state", 32'(state), 0);
    check("rst_gen", 32'(generate_en), 0);
    check("rst_score", 32'(score), 0);
    check("rst_over", 32'(game_over), 0);
    check("rst_charge", 32'(charge), 0);
    check("rst_fall_en", 32'(fall_en), 0);
    rst = 1'b0;
    step();

    // Round 1: start, 10-pulse charge, good landing, normal fall
    start = 1; step(); start = 0;
    check("gen_state", 32'(state), 1);
    check("gen_strobe", 32'(generate_en), 1);
    step();
    check("wait_state", 32'(state), 2);
    check("gen_one_cycle", 32'(generate_en), 0);
    check("start_score", 32'(score), 0);
    check("start_over", 32'(game_over), 0);

    key = 1; step();
    check("charge_state", 32'(state), 3);
    check("charge_clear", 32'(charge), 0);
    pulses(10);
    check("charge_10", 32'(charge), 10);
    key = 0; step();
    check("jump_state", 32'(state), 4);
    check("jump_power_10", 32'(jump_power), 10);
    check("jump_start_hi", 32'(jump_start), 1);
    check("jump_en_hi", 32'(jump_en), 1);
    step();
    check("jump_start_lo", 32'(jump_start), 0);
    check("jump_en_hold", 32'(jump_en), 1);

    jump_fin = 1; land_ok = 1; land_center = 0; step();
    jump_fin = 0; land_ok = 0;
    check("judge_state", 32'(state), 5);
    check("judge_jump_en", 32'(jump_en), 0);
    step();
    check("update_state", 32'(state), 6);
    check("update_hi", 32'(update), 1);
    check("score_1", 32'(score), 1);
    step();
    check("fall_state", 32'(state), 7);
    check("update_lo", 32'(update), 0);
    check("fall_en_hi", 32'(fall_en), 1);
    pulses(100);
    check("fall_still", 32'(state), 7);
    fall_fin = 1; step(); fall_fin = 0;
    check("fall_fin_state", 32'(state), 2);
    check("fall_fin_err", 32'(fall_err), 0);
    check("fall_en_lo", 32'(fall_en), 0);

    // Round 2: charge saturation, centre landing, fall timeout
    key = 1; step();
    check("r2_charge", 32'(state), 3);
    pulses(250);
    check("charge_sat", 32'(charge), 200);
    key = 0; step();
    check("jump_power_sat", 32'(jump_power), 200);
    jump_fin = 1; land_ok = 1; land_center = 1; step();
    jump_fin = 0; land_ok = 0; land_center = 0;
    step();
    check("bonus_score", 32'(score), 32'(exp_bonus_score));
    step();
    pulses(119);
    check("to_119_state", 32'(state), 7);
    pulse = 1; step(); pulse = 0;
    check("to_state", 32'(state), 2);
    check("to_err", 32'(fall_err), 1);
    check("charge_held", 32'(charge), 200);

    // Round 3: zero-charge jump, missed landing, restart
    key = 1; step(); key = 0; step();
    check("jump_power_0", 32'(jump_power), 0);
    jump_fin = 1; land_ok = 0; step(); jump_fin = 0;
    step();
    check("over_state", 32'(state), 0);
    check("over_flag", 32'(game_over), 1);
    step(); step();
    check("over_held", 32'(game_over), 1);
    start = 1; step(); start = 0;
    check("restart_gen", 32'(generate_en), 1);
    check("restart_score", 32'(score), 0);
    check("restart_over", 32'(game_over), 0);
    check("restart_err", 32'(fall_err), 0);
    step();

    // Round 4: fall_fin beats timeout, key held on WAIT_KEY entry
    key = 1; step();
    pulses(3);
    check("charge_3", 32'(charge), 3);
    key = 0;
    pulse = 1; step(); pulse = 0;
    check("release_pulse_power", 32'(jump_power), 4);
    jump_fin = 1; land_ok = 1; step(); jump_fin = 0; land_ok = 0;
    step(); step();
    check("r4_fall", 32'(state), 7);
    key = 1;
    pulses(119);
    pulse = 1; fall_fin = 1; step(); pulse = 0; fall_fin = 0;
    check("tie_state", 32'(state), 2);
    check("tie_err", 32'(fall_err), 0);
    step(); step();
    check("held_key_ignored", 32'(state), 2);
    key = 0; step();
    check("release_wait", 32'(state), 2);
    key = 1; step();
    check("repress_charge", 32'(state), 3);

    // Reset mid-round aborts
    rst = 1; #2;
    check("async_rst_state", 32'(state), 0);
    check("async_rst_score", 32'(score), 0);
    rst = 0; key = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_round_ctrl.md
Name: stage_round_ctrl

Overview:
- Game-round sequencer for the jump game.
- Drives the stage-fall animator through its generate_en/update/enable controls and runs the key-charge/jump/landing-judge loop.
- Accumulates the score and flags game over; sits between the debounced key input, the frame-pulse generator, the stage-fall animator and the jumper/collision logic.

Parameters:
- CHARGE_W, 8, width of charge counter / jump_power
- CHARGE_MAX, 200, saturation value of charge
- SCORE_W, 10, width of score
- FALL_TIMEOUT, 120, max frame pulses spent in FALL before forced exit (nominal fall is 100 pulses)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle start/restart request
- key  in  1  debounced jump key level (1 = pressed)
- pulse  in  1  one-cycle frame tick
- fall_fin  in  1  stage fall complete (from animator)
- jump_fin  in  1  jump trajectory complete
- land_ok  in  1  landing-on-stage result, valid while jump_fin=1
- land_center  in  1  landed in stage centre zone, valid with land_ok
- generate_en  out  1  load initial stage (to animator)
- update  out  1  restart fall from top (to animator)
- fall_en  out  1  animator enable
- jump_start  out  1  one-cycle jump launch
- jump_en  out  1  jump in progress
- jump_power  out  CHARGE_W  latched charge for current jump
- charge  out  CHARGE_W  live charge value
- score  out  SCORE_W  current score
- game_over  out  1  round lost
- fall_err  out  1  sticky: FALL exited via timeout
- state  out  3  FSM state code

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; every output 0; key_prev=0; timeout counter=0.
- All outputs are registered; each one-cycle strobe is high for exactly the cycle the FSM spends in the corresponding state.
- State codes: IDLE=0, GEN=1, WAIT_KEY=2, CHARGE=3, JUMP=4, JUDGE=5, UPDATE=6, FALL=7.
- Game over is held in IDLE with game_over=1.
- IDLE: start=1 -> GEN; on this transition clear score, game_over and fall_err.
- GEN: generate_en=1 for 1 cycle -> WAIT_KEY.
- WAIT_KEY:
  - Rising edge of key (key=1, key_prev=0) -> CHARGE, charge cleared to 0.
  - A key already held on entry is ignored until it is released.
- CHARGE:
  - On each pulse, charge+1, saturating at CHARGE_MAX.
  - key=0 -> JUMP, with jump_power<=charge and jump_start=1 for the first JUMP cycle.
  - If release and pulse coincide, the increment is applied before latching.
- JUMP: jump_en=1 until jump_fin=1 -> JUDGE, sampling land_ok/land_center into a register.
- JUDGE (1 cycle):
  - land_ok=1: score+1, saturating at all-ones -> UPDATE.
  - land_ok=0: game_over<=1 -> IDLE.
- UPDATE: update=1 for 1 cycle -> FALL; timeout counter cleared.
- FALL:
  - fall_en=1; the counter increments on each pulse.
  - fall_fin=1 -> WAIT_KEY.
  - Counter reaching FALL_TIMEOUT with no fall_fin -> WAIT_KEY and fall_err<=1.
- Priority: fall_fin beats timeout in the same cycle.
- Inputs are ignored outside their own states: start outside IDLE, fall_fin outside FALL, jump_fin outside JUMP.
- key_prev updates every cycle in all states.
- Charge holds its value outside CHARGE; it is cleared only on entry to CHARGE.
- Reset asserted mid-round aborts immediately; no strobe completes.

Optional Feature:
- Macro: PERFECT_BONUS_EN.
- Defined: in JUDGE, land_ok=1 with land_center=1 adds 2 to score (saturating); otherwise +1.
- Undefined: land_center is ignored and every successful landing adds 1.

Test Plan:
- Reset then start: generate_en high exactly 1 cycle, state 1 -> 2, score=0, game_over=0.
- Key high across 10 pulses then low: charge=10, jump_power=10, jump_start one cycle; key held 250 pulses -> charge=200.
- jump_fin with land_ok=1: score 0->1, update 1 cycle, fall_en high; fall_fin after 100 pulses -> state=2, fall_err=0.
- FALL with no fall_fin for 120 pulses -> state=2, fall_err=1; fall_fin and 120th pulse in same cycle -> fall_err stays 0.
- jump_fin with land_ok=0 -> game_over=1, state=0; start -> score=0, game_over=0, generate_en pulse.
- PERFECT_BONUS_EN: land_ok=1, land_center=1 -> score+2; without macro -> +1; key held on WAIT_KEY entry produces no CHARGE until released and re-pressed.
